snake_body_display: RTL and testbench

SNAKE_BODY_DISPLAY -- requirements
Module: snake_body_display

---
 rtl/snake_body_display_pkg.sv | 23 ++
 rtl/tick_divider.sv | 29 ++
 rtl/snake_body_display.sv | 137 +++++++++++++
 tb/tb_snake_body_display.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_body_display_pkg.sv
// Shared types and constants for the snake body display: board positions and
// LED matrix geometry.
package snake_body_display_pkg;

    localparam int MATRIX_ROWS = 8;
    localparam int MATRIX_COLS = 16;
    localparam int ROW_W       = 3;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } pos_t;

    function automatic logic [7:0] pack_pos(input pos_t p);
        return {p.x, p.y};
    endfunction

    // A position with y[3] set can never match a 3-bit row, so it is never drawn.
    function automatic logic on_row(input pos_t p, input logic [ROW_W-1:0] row);
        return p.y == {1'b0, row};
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running prescaler: registered one-cycle tick every DIV clocks, first
// tick on the DIV-th rising edge after reset release.
module tick_divider #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
            tick      <= 1'b0;
        end else if (count_reg == LAST) begin
            count_reg <= '0;
            tick      <= 1'b1;
        end else begin
            count_reg <= count_reg + 1'b1;
            tick      <= 1'b0;
        end
    end

endmodule

// File: rtl/snake_body_display.sv
// Snake body tracker: head register, shifting body FIFO with tail/self-hit
// reporting, and a row-scanned 8x16 LED matrix driver.
module snake_body_display
    import snake_body_display_pkg::*;
#(
    parameter int UPDATE_DIV = 2,
    parameter int SCAN_DIV   = 1024,
    parameter int BODY_LEN   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             head_x,
    input  logic [3:0]             head_y,
    input  logic [3:0]             food_x,
    input  logic [3:0]             food_y,
    output logic                   update_tick,
    output logic [3:0]             tail_x,
    output logic [3:0]             tail_y,
    output logic                   tail_valid,
    output logic                   self_hit,
    output logic [MATRIX_ROWS-1:0] MATRIX_ROW,
    output logic [MATRIX_COLS-1:0] MATRIX_COL
);

    logic             scan_tick;
    pos_t             head_in;
    pos_t             food_pos;
    pos_t             head_reg;
    pos_t             body_reg [BODY_LEN];
    logic             valid_reg [BODY_LEN];
    logic             push;
    logic [ROW_W-1:0] row_reg;
    pos_t             tail_pos;
    logic             any_valid;
    logic             hit;
    logic [MATRIX_COLS-1:0] col_next;

    tick_divider #(.DIV(UPDATE_DIV)) u_update_div (
        .clk   (clk),
        .reset (reset),
        .tick  (update_tick)
    );

    tick_divider #(.DIV(SCAN_DIV)) u_scan_div (
        .clk   (clk),
        .reset (reset),
        .tick  (scan_tick)
    );

    assign head_in  = '{x: head_x, y: head_y};
    assign food_pos = '{x: food_x, y: food_y};
    assign push     = pack_pos(head_in) != pack_pos(head_reg);

    // Entry 0 is the newest; a push shifts everything one slot older and the
    // last slot simply falls off when the FIFO is full.
    genvar gi;
    generate
        for (gi = 0; gi < BODY_LEN; gi++) begin : g_fifo
            if (gi == 0) begin : g_newest
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        body_reg[gi]  <= '0;
                        valid_reg[gi] <= 1'b0;
                    end else if (push) begin
                        body_reg[gi]  <= head_reg;
                        valid_reg[gi] <= 1'b1;
                    end
                end
            end else begin : g_shift
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        body_reg[gi]  <= '0;
                        valid_reg[gi] <= 1'b0;
                    end else if (push) begin
                        body_reg[gi]  <= body_reg[gi-1];
                        valid_reg[gi] <= valid_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Valid bits fill contiguously from entry 0, so the highest valid index is the tail.
    always_comb begin
        tail_pos  = '0;
        any_valid = 1'b0;
        hit       = 1'b0;
        for (int i = 0; i < BODY_LEN; i++) begin
            if (valid_reg[i]) begin
                tail_pos  = body_reg[i];
                any_valid = 1'b1;
                if (pack_pos(body_reg[i]) == pack_pos(head_reg)) begin
                    hit = 1'b1;
                end
            end
        end
    end

    assign tail_x     = tail_pos.x;
    assign tail_y     = tail_pos.y;
    assign tail_valid = any_valid;
    assign self_hit   = hit;

    always_comb begin
        col_next = '0;
        if (on_row(head_reg, row_reg)) begin
            col_next[head_reg.x] = 1'b1;
        end
        if (on_row(food_pos, row_reg)) begin
            col_next[food_pos.x] = 1'b1;
        end
        for (int i = 0; i < BODY_LEN; i++) begin
            if (valid_reg[i] && on_row(body_reg[i], row_reg)) begin
                col_next[body_reg[i].x] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg   <= '0;
            row_reg    <= '0;
            MATRIX_ROW <= '0;
            MATRIX_COL <= '0;
        end else begin
            if (push) begin
                head_reg <= head_in;
            end
            if (scan_tick) begin
                row_reg <= row_reg + 1'b1;
            end
            MATRIX_ROW <= MATRIX_ROWS'(1) << row_reg;
            MATRIX_COL <= col_next;
        end
    end

endmodule

// File: tb/tb_snake_body_display.sv
// Scoreboard bench for snake_body_display: stimulus queues expectations, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_snake_body_display;

    localparam int SIG_TR   = 0;  // {update_tick, MATRIX_ROW}
    localparam int SIG_TAIL = 1;  // {tail_valid, tail_x, tail_y}
    localparam int SIG_HIT  = 2;  // self_hit
    localparam int SIG_COL  = 3;  // MATRIX_COL once MATRIX_ROW selects the given row
    localparam int SIG_RST  = 4;  // {MATRIX_ROW, MATRIX_COL, tail_valid, self_hit, update_tick}

    typedef struct {
        string       name;
        int          sig;
        int          row;
        logic [31:0] val;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [3:0]  head_x, head_y, food_x, food_y;
    logic        update_tick, tail_valid, self_hit;
    logic [3:0]  tail_x, tail_y;
    logic [7:0]  MATRIX_ROW;
    logic [15:0] MATRIX_COL;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   wait_cnt = 0;

    snake_body_display #(
        .UPDATE_DIV (2),
        .SCAN_DIV   (1),
        .BODY_LEN   (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .head_x      (head_x),
        .head_y      (head_y),
        .food_x      (food_x),
        .food_y      (food_y),
        .update_tick (update_tick),
        .tail_x      (tail_x),
        .tail_y      (tail_y),
        .tail_valid  (tail_valid),
        .self_hit    (self_hit),
        .MATRIX_ROW  (MATRIX_ROW),
        .MATRIX_COL  (MATRIX_COL)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] actual(input int sig);
        case (sig)
            SIG_TR:   return {23'd0, update_tick, MATRIX_ROW};
            SIG_TAIL: return {23'd0, tail_valid, tail_x, tail_y};
            SIG_HIT:  return {31'd0, self_hit};
            SIG_COL:  return {16'd0, MATRIX_COL};
            default:  return {5'd0, MATRIX_ROW, MATRIX_COL, tail_valid, self_hit, update_tick};
        endcase
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [7:0] want_row;
            e = q[0];
            want_row = 8'h01 << e.row;
            if (e.sig == SIG_COL && MATRIX_ROW != want_row && wait_cnt < 40) begin
                wait_cnt++;
            end else if (e.sig == SIG_COL && MATRIX_ROW != want_row) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: row select never reached, got MATRIX_ROW=%h required %h",
                         e.name, MATRIX_ROW, want_row);
                void'(q.pop_front());
                wait_cnt = 0;
            end else begin
                logic [31:0] a;
                a = actual(e.sig);
                n_checks++;
                if (a !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h required %h", e.name, a, e.val);
                end else begin
                    $display("ok   %s: %h", e.name, a);
                end
                void'(q.pop_front());
                wait_cnt = 0;
            end
        end
    end

    task automatic expect_val(input string name, input int sig, input int row, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.row  = row;
        e.val  = val;
        q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL drain: %0d expectations still pending, required 0", q.size());
        q.delete();
    endtask

    task automatic do_reset(input logic [3:0] fx, input logic [3:0] fy);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        head_x = 4'd0;
        head_y = 4'd0;
        food_x = fx;
        food_y = fy;
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic move(input logic [3:0] x, input logic [3:0] y);
        head_x = x;
        head_y = y;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] s1_rows [11];
    logic [3:0] s2_tx [6];
    logic [3:0] s4_x [5];
    logic [3:0] s4_y [5];
    logic       s4_hit [5];
    logic [15:0] s5_cols [8];

    initial begin
        s1_rows = '{8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
        s2_tx   = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2};
        s4_x    = '{4'd1, 4'd2, 4'd2, 4'd1, 4'd1};
        s4_y    = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd1};
        s4_hit  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        s5_cols = '{16'h0001, 16'h0000, 16'h0000, 16'h0000,
                    16'h0000, 16'h0000, 16'h0000, 16'h8000};

        reset  = 1'b0;
        head_x = 4'd0;
        head_y = 4'd0;
        food_x = 4'd0;
        food_y = 4'd8;

        // Held in reset: everything reads zero.
        expect_val("reset_outputs", SIG_RST, 0, 32'd0);
        expect_val("reset_tail", SIG_TAIL, 0, 32'd0);
        drain();

        // Scenario 1: tick every 2nd edge, row scan every cycle.
        @(negedge clk);
        #1;
        reset = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            logic tk;
            tk = (k % 2 == 0);
            expect_val($sformatf("s1_tick_row_c%0d", k), SIG_TR, 0, {23'd0, tk, s1_rows[k-1]});
        end
        drain();

        // Scenario 2: straight run, FIFO saturates and drops oldest.
        do_reset(4'd0, 4'd8);
        for (int m = 0; m < 6; m++) begin
            move(4'(m + 1), 4'd0);
            expect_val($sformatf("s2_tail_m%0d", m + 1), SIG_TAIL, 0, {23'd0, 1'b1, s2_tx[m], 4'd0});
            expect_val($sformatf("s2_hit_m%0d", m + 1), SIG_HIT, 0, 32'd0);
            drain();
        end

        // Scenario 3: head, body and food sharing row 2.
        do_reset(4'd9, 4'd2);
        move(4'd1, 4'd2);
        move(4'd2, 4'd2);
        move(4'd3, 4'd2);
        expect_val("s3_col_row2", SIG_COL, 2, 32'h0000_020E);
        expect_val("s3_col_row0", SIG_COL, 0, 32'h0000_0001);
        expect_val("s3_tail", SIG_TAIL, 0, {23'd0, 1'b1, 4'd0, 4'd0});
        drain();

        // Scenario 4: loop back onto own body.
        do_reset(4'd0, 4'd8);
        for (int m = 0; m < 5; m++) begin
            move(s4_x[m], s4_y[m]);
            expect_val($sformatf("s4_hit_m%0d", m + 1), SIG_HIT, 0, {31'd0, s4_hit[m]});
            drain();
        end

        // Scenario 5: off-screen food never drawn; corner head drawn.
        do_reset(4'd5, 4'd9);
        move(4'd15, 4'd7);
        for (int r = 0; r < 8; r++) begin
            expect_val($sformatf("s5_col_row%0d", r), SIG_COL, r, {16'd0, s5_cols[r]});
        end
        drain();

        // Scenario 6: asynchronous clear with three body entries.
        do_reset(4'd0, 4'd8);
        move(4'd1, 4'd0);
        move(4'd2, 4'd0);
        move(4'd3, 4'd0);
        expect_val("s6_tail_before", SIG_TAIL, 0, {23'd0, 1'b1, 4'd0, 4'd0});
        expect_val("s6_col_before", SIG_COL, 0, 32'h0000_000F);
        drain();
        reset = 1'b0;
        expect_val("s6_async_clear", SIG_RST, 0, 32'd0);
        drain();
        @(negedge clk);
        #1;
        reset = 1'b1;
        expect_val("s6_release_c1", SIG_TR, 0, {23'd0, 1'b0, 8'h01});
        expect_val("s6_release_c2", SIG_TR, 0, {23'd0, 1'b1, 8'h01});
        expect_val("s6_release_c3", SIG_TR, 0, {23'd0, 1'b0, 8'h02});
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
